// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types and widths used by the writeback stage and its load aligner.
package rv32_pkg;
   localparam int XLEN      = 32;
   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      MEM_B   = 2'b00,
      MEM_H   = 2'b01,
      MEM_W   = 2'b10,
      MEM_RSV = 2'b11
   } mem_width_t;
endpackage

// File: rtl/rv32_load_align.sv
// Combinational load extractor: picks the byte/half/word lane from an aligned memory word,
// extends it, and reports whether the access address is misaligned for its width.
module rv32_load_align
   import rv32_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr_lo,
   input  mem_width_t      width,
   input  logic            is_unsigned,
   output logic [XLEN-1:0] value,
   output logic            misaligned
);
   logic signed [7:0]  byte_sel;
   logic signed [15:0] half_sel;

   always_comb begin
      byte_sel   = rdata[8*addr_lo +: 8];
      half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      value      = rdata;
      misaligned = 1'b0;
      case (width)
         MEM_B: begin
            value = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         MEM_H: begin
            value      = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            misaligned = addr_lo[0];
         end
         // reserved width behaves as a full word
         default: begin
            value      = rdata;
            misaligned = (addr_lo != 2'b00);
         end
      endcase
   end
endmodule

// File: rtl/rv32_writeback.sv
// RV32 writeback stage: registers the memory-stage result for the regfile write port,
// aligns load data, flags misaligned loads and counts retired instructions.
module rv32_writeback
   import rv32_pkg::*;
#(
   parameter int INSTRET_W = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 stall_in,
   input  logic                 flush_in,
   input  logic                 valid_in,
   input  logic [REG_IDX_W-1:0] rd_in,
   input  logic                 rd_write_in,
   input  logic [XLEN-1:0]      result_in,
   input  logic                 mem_read_in,
   input  logic [1:0]           mem_width_in,
   input  logic                 mem_unsigned_in,
   input  logic [1:0]           mem_addr_lo_in,
   input  logic [XLEN-1:0]      mem_rdata_in,
   output logic [REG_IDX_W-1:0] rd_out,
   output logic                 rd_write_out,
   output logic [XLEN-1:0]      rd_value_out,
   output logic                 writeback_flush_out,
   output logic                 valid_out,
   output logic                 misaligned_out,
   output logic [INSTRET_W-1:0] instret_out
);
   logic [XLEN-1:0]      ld_value;
   logic                 ld_misaligned;
   logic                 mis_now;

   logic [REG_IDX_W-1:0] rd_d, rd_q;
   logic                 rd_write_d, rd_write_q;
   logic [XLEN-1:0]      rd_value_d, rd_value_q;
   logic                 flush_d, flush_q;
   logic                 valid_d, valid_q;
   logic                 misaligned_d, misaligned_q;
   logic [INSTRET_W-1:0] instret_d, instret_q;

   rv32_load_align u_align (
      .rdata       (mem_rdata_in),
      .addr_lo     (mem_addr_lo_in),
      .width       (mem_width_t'(mem_width_in)),
      .is_unsigned (mem_unsigned_in),
      .value       (ld_value),
      .misaligned  (ld_misaligned)
   );

   assign mis_now = valid_in & mem_read_in & ld_misaligned;

   always_comb begin
      rd_d         = rd_q;
      rd_write_d   = rd_write_q;
      rd_value_d   = rd_value_q;
      flush_d      = flush_q;
      valid_d      = valid_q;
      misaligned_d = 1'b0;
      instret_d    = instret_q;
      if (flush_in) begin
         // flush beats stall; rd and value are left as they were
         valid_d    = 1'b0;
         rd_write_d = 1'b0;
         flush_d    = 1'b1;
      end else if (!stall_in) begin
         rd_d         = rd_in;
         rd_value_d   = mem_read_in ? ld_value : result_in;
         valid_d      = valid_in;
         flush_d      = !valid_in;
         misaligned_d = mis_now;
         rd_write_d   = valid_in & rd_write_in & (rd_in != '0) & !mis_now;
         if (valid_in) begin
            instret_d = instret_q + INSTRET_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_q         <= '0;
         rd_write_q   <= 1'b0;
         rd_value_q   <= '0;
         flush_q      <= 1'b1;
         valid_q      <= 1'b0;
         misaligned_q <= 1'b0;
         instret_q    <= '0;
      end else begin
         rd_q         <= rd_d;
         rd_write_q   <= rd_write_d;
         rd_value_q   <= rd_value_d;
         flush_q      <= flush_d;
         valid_q      <= valid_d;
         misaligned_q <= misaligned_d;
         instret_q    <= instret_d;
      end
   end

   assign rd_out              = rd_q;
   assign rd_write_out        = rd_write_q;
   assign rd_value_out        = rd_value_q;
   assign writeback_flush_out = flush_q;
   assign valid_out           = valid_q;
   assign misaligned_out      = misaligned_q;
   assign instret_out         = instret_q;
endmodule

// File: tb/tb_rv32_writeback.sv
// Bench for rv32_writeback: directed vector table, randomized run against a behavioural
// model, and hand sequences for stall/flush, asynchronous reset and 32-bit counter wrap.
module tb_rv32_writeback;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        stall_in, flush_in, valid_in, rd_write_in, mem_read_in, mem_unsigned_in;
   logic [4:0]  rd_in;
   logic [31:0] result_in, mem_rdata_in;
   logic [1:0]  mem_width_in, mem_addr_lo_in;

   logic [4:0]  rd_out, rd_out32;
   logic        rd_write_out, wb_flush_out, valid_out, mis_out;
   logic        rd_write_out32, wb_flush_out32, valid_out32, mis_out32;
   logic [31:0] rd_value_out, rd_value_out32;
   logic [63:0] instret_out;
   logic [31:0] instret_out32;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv32_writeback #(.INSTRET_W(64)) u_dut (
      .clk(clk), .reset_n(reset_n), .stall_in(stall_in), .flush_in(flush_in),
      .valid_in(valid_in), .rd_in(rd_in), .rd_write_in(rd_write_in), .result_in(result_in),
      .mem_read_in(mem_read_in), .mem_width_in(mem_width_in),
      .mem_unsigned_in(mem_unsigned_in), .mem_addr_lo_in(mem_addr_lo_in),
      .mem_rdata_in(mem_rdata_in), .rd_out(rd_out), .rd_write_out(rd_write_out),
      .rd_value_out(rd_value_out), .writeback_flush_out(wb_flush_out),
      .valid_out(valid_out), .misaligned_out(mis_out), .instret_out(instret_out)
   );

   rv32_writeback #(.INSTRET_W(32)) u_dut32 (
      .clk(clk), .reset_n(reset_n), .stall_in(stall_in), .flush_in(flush_in),
      .valid_in(valid_in), .rd_in(rd_in), .rd_write_in(rd_write_in), .result_in(result_in),
      .mem_read_in(mem_read_in), .mem_width_in(mem_width_in),
      .mem_unsigned_in(mem_unsigned_in), .mem_addr_lo_in(mem_addr_lo_in),
      .mem_rdata_in(mem_rdata_in), .rd_out(rd_out32), .rd_write_out(rd_write_out32),
      .rd_value_out(rd_value_out32), .writeback_flush_out(wb_flush_out32),
      .valid_out(valid_out32), .misaligned_out(mis_out32), .instret_out(instret_out32)
   );

   typedef struct {
      logic        stall, flush, valid;
      logic [4:0]  rd;
      logic        rdw;
      logic [31:0] result;
      logic        mr;
      logic [1:0]  width;
      logic        uns;
      logic [1:0]  addr;
      logic [31:0] rdata;
      logic [4:0]  e_rd;
      logic        e_wr;
      logic [31:0] e_val;
      logic        e_valid, e_flush, e_mis;
      longint unsigned e_instret;
   } vec_t;

   vec_t vecs[13];

   // behavioural model state
   logic [4:0]      m_rd;
   logic            m_wr, m_valid, m_flush, m_mis;
   logic [31:0]     m_val;
   longint unsigned m_instret;

   function automatic vec_t mk(logic st, logic fl, logic v, logic [4:0] rd, logic rdw,
                               logic [31:0] res, logic mr, logic [1:0] w, logic u,
                               logic [1:0] a, logic [31:0] rdat, logic [4:0] erd,
                               logic ewr, logic [31:0] ev, logic evl, logic efl,
                               logic ems, longint unsigned ei);
      vec_t t;
      t.stall = st; t.flush = fl; t.valid = v; t.rd = rd; t.rdw = rdw; t.result = res;
      t.mr = mr; t.width = w; t.uns = u; t.addr = a; t.rdata = rdat;
      t.e_rd = erd; t.e_wr = ewr; t.e_val = ev; t.e_valid = evl; t.e_flush = efl;
      t.e_mis = ems; t.e_instret = ei;
      return t;
   endfunction

   function automatic int unsigned ref_bits(logic [1:0] w);
      return (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
   endfunction

   function automatic logic [31:0] ref_load(logic [31:0] rdata, logic [1:0] w, logic u,
                                            logic [1:0] a);
      int unsigned bits = ref_bits(w);
      longint      shift = (bits == 8) ? 8 * a : (bits == 16) ? 16 * (a / 2) : 0;
      longint      raw = longint'(rdata) >> shift;
      longint      span = longint'(1) << bits;
      raw = raw % span;
      if (!u && raw >= span / 2) raw = raw - span;
      return raw[31:0];
   endfunction

   function automatic logic ref_mis(logic [1:0] w, logic [1:0] a);
      int unsigned bits = ref_bits(w);
      return (bits == 16 && (a % 2) != 0) || (bits == 32 && a != 0);
   endfunction

   task automatic chk(string nm, longint unsigned act, longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(string tag, logic [4:0] erd, logic ewr, logic [31:0] ev,
                          logic evl, logic efl, logic ems, longint unsigned ei);
      chk({tag, ".rd"}, rd_out, erd);
      chk({tag, ".wr"}, rd_write_out, ewr);
      chk({tag, ".val"}, rd_value_out, ev);
      chk({tag, ".valid"}, valid_out, evl);
      chk({tag, ".flush"}, wb_flush_out, efl);
      chk({tag, ".mis"}, mis_out, ems);
      chk({tag, ".instret"}, instret_out, ei);
   endtask

   task automatic drive(logic st, logic fl, logic v, logic [4:0] rd, logic rdw,
                        logic [31:0] res, logic mr, logic [1:0] w, logic u,
                        logic [1:0] a, logic [31:0] rdat);
      stall_in = st; flush_in = fl; valid_in = v; rd_in = rd; rd_write_in = rdw;
      result_in = res; mem_read_in = mr; mem_width_in = w; mem_unsigned_in = u;
      mem_addr_lo_in = a; mem_rdata_in = rdat;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(0, 0, 0, 5'd0, 0, 32'd0, 0, 2'd0, 0, 2'd0, 32'd0);
      step();
      step();
      chk_all("reset", 5'd0, 0, 32'd0, 0, 1, 0, 0);
      chk("reset.instret32", instret_out32, 0);
      reset_n = 1'b1;
   endtask

   initial begin
      // directed table: rdata 0x80FF7F01 exercises every extraction lane
      vecs[0]  = mk(0,0,1, 5'd5, 1, 32'hDEADBEEF, 0,2'd0,0,2'd0, 32'h0,
                    5'd5, 1, 32'hDEADBEEF, 1,0,0, 1);
      vecs[1]  = mk(0,0,1, 5'd6, 1, 32'h0, 1,2'd0,0,2'd3, 32'h80FF7F01,
                    5'd6, 1, 32'hFFFFFF80, 1,0,0, 2);
      vecs[2]  = mk(0,0,1, 5'd6, 1, 32'h0, 1,2'd0,1,2'd3, 32'h80FF7F01,
                    5'd6, 1, 32'h00000080, 1,0,0, 3);
      vecs[3]  = mk(0,0,1, 5'd6, 1, 32'h0, 1,2'd1,0,2'd2, 32'h80FF7F01,
                    5'd6, 1, 32'hFFFF80FF, 1,0,0, 4);
      vecs[4]  = mk(0,0,1, 5'd7, 1, 32'h0, 1,2'd2,0,2'd2, 32'h80FF7F01,
                    5'd7, 0, 32'h80FF7F01, 1,0,1, 5);
      vecs[5]  = mk(0,0,1, 5'd0, 1, 32'h1234, 0,2'd0,0,2'd0, 32'h0,
                    5'd0, 0, 32'h1234, 1,0,0, 6);
      vecs[6]  = mk(0,0,0, 5'd9, 1, 32'h55, 0,2'd0,0,2'd0, 32'h0,
                    5'd9, 0, 32'h55, 0,1,0, 6);
      vecs[7]  = mk(0,0,1, 5'd3, 1, 32'h0, 1,2'd1,1,2'd0, 32'h80FF7F01,
                    5'd3, 1, 32'h00007F01, 1,0,0, 7);
      vecs[8]  = mk(0,0,1, 5'd3, 1, 32'h0, 1,2'd1,0,2'd1, 32'h80FF7F01,
                    5'd3, 0, 32'h00007F01, 1,0,1, 8);
      vecs[9]  = mk(0,0,1, 5'd4, 1, 32'h0, 1,2'd3,0,2'd0, 32'h80FF7F01,
                    5'd4, 1, 32'h80FF7F01, 1,0,0, 9);
      vecs[10] = mk(0,1,1, 5'd8, 1, 32'h77, 0,2'd0,0,2'd0, 32'h0,
                    5'd4, 0, 32'h80FF7F01, 0,1,0, 9);
      vecs[11] = mk(0,0,1, 5'd10, 1, 32'h0, 1,2'd0,0,2'd1, 32'h80FF7F01,
                    5'd10, 1, 32'h0000007F, 1,0,0, 10);
      vecs[12] = mk(0,0,0, 5'd11, 1, 32'h0, 1,2'd2,0,2'd2, 32'h80FF7F01,
                    5'd11, 0, 32'h80FF7F01, 0,1,0, 10);

      do_reset();
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].rd, vecs[i].rdw,
               vecs[i].result, vecs[i].mr, vecs[i].width, vecs[i].uns, vecs[i].addr,
               vecs[i].rdata);
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_val,
                 vecs[i].e_valid, vecs[i].e_flush, vecs[i].e_mis, vecs[i].e_instret);
      end

      // stall freezes a captured ALU op, then flush overrides a concurrent stall
      do_reset();
      drive(0, 0, 1, 5'd12, 1, 32'hA5A5A5A5, 0, 2'd0, 0, 2'd0, 32'h0);
      step();
      chk_all("pre_stall", 5'd12, 1, 32'hA5A5A5A5, 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 5'd13, 1, 32'h11111111, 1, 2'd2, 0, 2'd1, 32'h0);
         step();
         chk_all($sformatf("stall%0d", i), 5'd12, 1, 32'hA5A5A5A5, 1, 0, 0, 1);
      end
      drive(1, 1, 1, 5'd14, 1, 32'h22222222, 0, 2'd0, 0, 2'd0, 32'h0);
      step();
      chk_all("flush_stall", 5'd12, 0, 32'hA5A5A5A5, 0, 1, 0, 1);

      // misaligned flag lasts one cycle when the next cycle stalls
      drive(0, 0, 1, 5'd2, 1, 32'h0, 1, 2'd1, 0, 2'd3, 32'hCAFEF00D);
      step();
      chk_all("mis_cap", 5'd2, 0, 32'hFFFFCAFE, 1, 0, 1, 2);
      drive(1, 0, 1, 5'd2, 1, 32'h0, 1, 2'd1, 0, 2'd3, 32'hCAFEF00D);
      step();
      chk_all("mis_stall", 5'd2, 0, 32'hFFFFCAFE, 1, 0, 0, 2);

      // asynchronous reset between edges
      drive(0, 0, 1, 5'd15, 1, 32'h33333333, 0, 2'd0, 0, 2'd0, 32'h0);
      step();
      chk_all("pre_areset", 5'd15, 1, 32'h33333333, 1, 0, 0, 3);
      #2 reset_n = 1'b0;
      #1;
      chk_all("areset", 5'd0, 0, 32'd0, 0, 1, 0, 0);
      chk("areset.instret32", instret_out32, 0);
      #1 reset_n = 1'b1;

      // 32-bit counter wraps to zero
      drive(0, 0, 0, 5'd0, 0, 32'h0, 0, 2'd0, 0, 2'd0, 32'h0);
      step();
      force u_dut32.instret_q = 32'hFFFFFFFF;
      #1 release u_dut32.instret_q;
      #1;
      chk("wrap.preload", instret_out32, 32'hFFFFFFFF);
      drive(0, 0, 1, 5'd1, 1, 32'h44, 0, 2'd0, 0, 2'd0, 32'h0);
      step();
      chk("wrap.instret32", instret_out32, 0);
      chk("wrap.instret64", instret_out, 1);

      // randomized run against the behavioural model
      do_reset();
      m_rd = 0; m_wr = 0; m_val = 0; m_valid = 0; m_flush = 1; m_mis = 0; m_instret = 0;
      for (int i = 0; i < 400; i++) begin
         logic st, fl, v, rdw, mr, u;
         logic [4:0] rd;
         logic [1:0] w, a;
         logic [31:0] res, rdat;
         st = ($urandom_range(0, 99) < 20);
         fl = ($urandom_range(0, 99) < 10);
         v = ($urandom_range(0, 99) < 75);
         rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         rdw = ($urandom_range(0, 3) != 0);
         mr = $urandom_range(0, 1) == 1;
         w = 2'($urandom);
         u = $urandom_range(0, 1) == 1;
         a = 2'($urandom);
         res = $urandom;
         rdat = $urandom;
         drive(st, fl, v, rd, rdw, res, mr, w, u, a, rdat);
         if (fl) begin
            m_valid = 0; m_wr = 0; m_flush = 1; m_mis = 0;
         end else if (st) begin
            m_mis = 0;
         end else begin
            logic mis;
            mis = v && mr && ref_mis(w, a);
            m_rd = rd;
            m_val = mr ? ref_load(rdat, w, u, a) : res;
            m_valid = v;
            m_flush = !v;
            m_mis = mis;
            m_wr = v && rdw && (rd != 0) && !mis;
            if (v) m_instret = m_instret + 1;
         end
         step();
         chk_all($sformatf("rnd%0d", i), m_rd, m_wr, m_val, m_valid, m_flush, m_mis,
                 m_instret);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rv32_writeback.md
Name: rv32_writeback

Overview:
- Final pipeline stage of the RV32 core, directly upstream of the register file.
- Captures memory-stage results, extracts and sign/zero-extends load data, and qualifies the register write.
- Presents the registered rd index, write enable, value and flush qualifier to the register file write port.
- Also owns the 64-bit retired-instruction counter (instret) and flags misaligned loads.

Parameters:
- INSTRET_W, 64, width of retired-instruction counter (legal 32..64)

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- stall_in  in  1  hold stage contents
- flush_in  in  1  kill instruction entering this stage
- valid_in  in  1  memory stage holds a real instruction
- rd_in  in  5  destination register index
- rd_write_in  in  1  instruction writes rd
- result_in  in  32  ALU/CSR result (non-load value)
- mem_read_in  in  1  instruction is a load
- mem_width_in  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_unsigned_in  in  1  zero-extend (LBU/LHU)
- mem_addr_lo_in  in  2  load address bits [1:0]
- mem_rdata_in  in  32  raw aligned memory word
- rd_out  out  5  to regfile rd_in
- rd_write_out  out  1  to regfile rd_write_in
- rd_value_out  out  32  to regfile rd_value_in
- writeback_flush_out  out  1  to regfile writeback_flush_in; high when stage holds a bubble
- valid_out  out  1  stage holds a retiring instruction
- misaligned_out  out  1  one-cycle flag: load captured this cycle was misaligned
- instret_out  out  INSTRET_W  retired-instruction count

Behaviour:
- Reset (async, reset_n=0): rd_out=0, rd_write_out=0, rd_value_out=0, valid_out=0, writeback_flush_out=1, misaligned_out=0, instret_out=0. All outputs are registered.
- Latency: one cycle from inputs to outputs.
- Per posedge, priority order:
  1. flush_in=1: capture a bubble regardless of stall_in. valid_out=0, rd_write_out=0, writeback_flush_out=1; rd_out and rd_value_out are don't-care but held.
  2. stall_in=1: hold every output. misaligned_out goes to 0; instret does not count.
  3. Otherwise: capture the inputs. valid_out=valid_in, writeback_flush_out=!valid_in.
- Load data (mem_read_in=1):
  - byte: select mem_rdata_in[8*addr_lo+7 -: 8].
  - half: select the halfword at addr_lo[1].
  - word: full word.
  - Then sign-extend, or zero-extend if mem_unsigned_in.
  - Width 11 is treated as word.
- Non-load: rd_value_out=result_in.
- Misaligned load (valid_in & mem_read_in & half with addr_lo[0]=1, or word with addr_lo!=0): misaligned_out=1 for that cycle, rd_write_out=0, valid_out=1 (the instruction still retires).
- rd_write_out = valid_in & rd_write_in & (rd_in!=0) & !misaligned. x0 writes are suppressed here as well as in the regfile.
- instret increments by 1 on each non-stalled, non-flushed capture with valid_in=1 (misaligned included). It wraps modulo 2^INSTRET_W with no saturation.
- Simultaneous flush_in & stall_in: flush wins and instret does not count.
- Reset asserted mid-stall or mid-flush: outputs go to reset values immediately (asynchronous).

Decomposition:
- Shared package rv32_pkg:
  - mem_width_t enum (MEM_B, MEM_H, MEM_W, MEM_RSV);
  - XLEN=32 constant;
  - REG_IDX_W=5 constant.
- One combinational sub-module, rv32_load_align (rdata, addr_lo, width, unsigned -> value, misaligned), reusable by the memory stage.
- Counter and pipeline register live in rv32_writeback.

Test Plan:
- Reset, then ALU op rd=5, result 0xDEADBEEF, valid=1 -> next cycle rd_out=5, rd_write_out=1, rd_value_out=0xDEADBEEF, instret=1.
- LB with rdata 0x80FF7F01, addr_lo=3 -> 0xFFFFFF80; same with LBU -> 0x00000080; LH with addr_lo=2 -> 0xFFFF80FF.
- LW with addr_lo=2 -> misaligned_out=1 for one cycle, rd_write_out=0, instret increments.
- Valid ALU op with stall_in=1 for 3 cycles -> outputs frozen and instret unchanged. Assert flush_in together with stall_in -> writeback_flush_out=1, valid_out=0.
- rd_in=0 with rd_write_in=1 -> rd_write_out=0, instret still increments.
- With INSTRET_W=32, preload via 2^32-1 valid retirements (or force), then one more retirement -> instret_out=0. Assert reset_n=0 asynchronously mid-clock -> all outputs at reset values before the next edge.
